// File: rtl/led_pattern_gen_if.sv
// Configuration write port for led_pattern_gen: one valid/ready transfer
// loads the mode and level of a single channel.
interface led_pattern_gen_if #(
    parameter int CHAN_W   = 3,
    parameter int PWM_BITS = 8
);
    logic                CFG_VALID;
    logic                CFG_READY;
    logic [CHAN_W-1:0]   CFG_CHAN;
    logic [1:0]          CFG_MODE;
    logic [PWM_BITS-1:0] CFG_LEVEL;

    modport master (
        output CFG_VALID, CFG_CHAN, CFG_MODE, CFG_LEVEL,
        input  CFG_READY
    );

    modport slave (
        input  CFG_VALID, CFG_CHAN, CFG_MODE, CFG_LEVEL,
        output CFG_READY
    );
endinterface

// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: per-channel OFF/ON/BLINK/BREATHE modes rendered
// through one shared PWM counter, with a shared prescaled tick timebase.
module led_pattern_gen #(
    parameter int CLK_HZ      = 12000000,
    parameter int TICK_HZ     = 1000,
    parameter int NUM_LEDS    = 5,
    parameter int PWM_BITS    = 8,
    parameter int BLINK_TICKS = 250,
    parameter int RESET_MODE  = 2
) (
    input  logic                CLK,
    input  logic                RST,
    led_pattern_gen_if.slave    cfg,
    output logic                TICK,
    output logic [NUM_LEDS-1:0] LED
);
    localparam int PRESCALE = CLK_HZ / TICK_HZ;
    localparam int PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BLK_W    = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [PWM_BITS-1:0] FULL      = '1;
    localparam logic [1:0]          M_OFF     = 2'd0;
    localparam logic [1:0]          M_ON      = 2'd1;
    localparam logic [1:0]          M_BLINK   = 2'd2;
    localparam logic [1:0]          M_BREATHE = 2'd3;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PRE_W-1:0]    prescaler;
    logic [BLK_W-1:0]    blink_cnt;
    logic                blink_phase;
    logic                wr_en;

    logic [1:0]          mode     [NUM_LEDS];
    logic [PWM_BITS-1:0] level    [NUM_LEDS];
    logic [PWM_BITS-1:0] ramp     [NUM_LEDS];
    logic                dir_down [NUM_LEDS];
    logic [PWM_BITS-1:0] duty     [NUM_LEDS];

    // Full-scale duty is forced to a solid 1 so the LED never blinks off for one cycle.
    function automatic logic pwm_bit(input logic [PWM_BITS-1:0] cnt,
                                     input logic [PWM_BITS-1:0] d);
        return (d == FULL) ? 1'b1 : (cnt < d);
    endfunction

    assign wr_en = cfg.CFG_VALID & cfg.CFG_READY;

    // Shared timebase: PWM counter, tick prescaler and blink phase
    always_ff @(posedge CLK) begin
        if (RST) begin
            pwm_cnt       <= '0;
            prescaler     <= '0;
            TICK          <= 1'b0;
            blink_cnt     <= '0;
            blink_phase   <= 1'b1;
            cfg.CFG_READY <= 1'b0;
        end else begin
            pwm_cnt       <= pwm_cnt + 1'b1;
            cfg.CFG_READY <= 1'b1;
            if (prescaler == PRE_W'(PRESCALE - 1)) begin
                prescaler <= '0;
                TICK      <= 1'b1;
            end else begin
                prescaler <= prescaler + 1'b1;
                TICK      <= 1'b0;
            end
            if (TICK) begin
                if (blink_cnt == BLK_W'(BLINK_TICKS - 1)) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    // Per-channel state: a write on a tick edge overrides the breathe step
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (RST) begin
                mode[i]     <= 2'(RESET_MODE);
                level[i]    <= FULL;
                ramp[i]     <= '0;
                dir_down[i] <= 1'b0;
            end else begin
                if (TICK) begin
                    if (!dir_down[i]) begin
                        if (ramp[i] >= level[i]) dir_down[i] <= 1'b1;
                        else                     ramp[i]     <= ramp[i] + 1'b1;
                    end else begin
                        if (ramp[i] == '0) dir_down[i] <= 1'b0;
                        else               ramp[i]     <= ramp[i] - 1'b1;
                    end
                end
                if (wr_en && (int'(cfg.CFG_CHAN) == i)) begin
                    mode[i]  <= cfg.CFG_MODE;
                    level[i] <= cfg.CFG_LEVEL;
                    if (cfg.CFG_MODE == M_BREATHE) begin
                        ramp[i]     <= '0;
                        dir_down[i] <= 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            duty[i] = '0;
            case (mode[i])
                M_OFF:     duty[i] = '0;
                M_ON:      duty[i] = level[i];
                M_BLINK:   duty[i] = blink_phase ? level[i] : '0;
                M_BREATHE: duty[i] = ramp[i];
                default:   duty[i] = '0;
            endcase
        end
    end

    // Registered PWM output stage
    always_ff @(posedge CLK) begin
        if (RST) begin
            LED <= '0;
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) LED[i] <= pwm_bit(pwm_cnt, duty[i]);
        end
    end
endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: stimulus queues cycle-stamped
// expectations, a negedge monitor pops and compares them against the DUT.
module tb_led_pattern_gen;
    localparam int CLK_HZ      = 1000;
    localparam int TICK_HZ     = 100;
    localparam int NUM_LEDS    = 3;
    localparam int PWM_BITS    = 4;
    localparam int BLINK_TICKS = 3;
    localparam int RESET_MODE  = 2;
    localparam int CHAN_W      = 2;

    localparam int K_LED  = 0;
    localparam int K_TICK = 1;
    localparam int K_RDY  = 2;
    localparam int K_BIT  = 3;

    typedef struct {
        int         cyc;
        int         kind;
        int         bitn;
        logic [2:0] exp;
        string      name;
    } exp_t;

    logic                CLK = 1'b0;
    logic                RST = 1'b1;
    logic                TICK;
    logic [NUM_LEDS-1:0] LED;
    int                  cyc = 0;
    int                  n_chk = 0;
    int                  n_fail = 0;
    exp_t                sb[$];
    exp_t                m_e;
    logic [2:0]          m_act;

    // Hand-computed breathe ramp for level=3 after each tick following the write
    int ramp_tab[12] = '{1, 2, 3, 3, 2, 1, 0, 0, 1, 2, 3, 3};

    led_pattern_gen_if #(.CHAN_W(CHAN_W), .PWM_BITS(PWM_BITS)) cfg ();

    led_pattern_gen #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .NUM_LEDS(NUM_LEDS),
        .PWM_BITS(PWM_BITS), .BLINK_TICKS(BLINK_TICKS), .RESET_MODE(RESET_MODE)
    ) dut (
        .CLK(CLK), .RST(RST), .cfg(cfg), .TICK(TICK), .LED(LED)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic expect_at(input int c, input int k, input int b,
                             input logic [2:0] v, input string nm);
        exp_t e;
        e.cyc = c; e.kind = k; e.bitn = b; e.exp = v; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge CLK);
    endtask

    task automatic do_write(input int at_edge, input int chan, input int mode, input int lvl);
        wait_cyc(at_edge - 1);
        cfg.CFG_VALID = 1'b1;
        cfg.CFG_CHAN  = CHAN_W'(chan);
        cfg.CFG_MODE  = 2'(mode);
        cfg.CFG_LEVEL = PWM_BITS'(lvl);
        wait_cyc(at_edge);
        cfg.CFG_VALID = 1'b0;
    endtask

    // PWM bit for edge e: the counter seen at edge e was cleared by the last reset edge er
    function automatic logic pwm_exp(input int e, input int er, input int d);
        if (d == 15) return 1'b1;
        return ((e - 1 - er) % 16) < d;
    endfunction

    function automatic logic phase_after(input int x);
        return (((x - 3) / 30) % 2) == 0;
    endfunction

    function automatic int ramp_eff(input int e);
        if (e <= 133) return 0;
        return ramp_tab[(e - 134) / 10];
    endfunction

    always @(negedge CLK) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                m_e = sb[i];
                sb.delete(i);
                n_chk++;
                case (m_e.kind)
                    K_LED:   m_act = LED;
                    K_TICK:  m_act = {2'b00, TICK};
                    K_RDY:   m_act = {2'b00, cfg.CFG_READY};
                    default: m_act = {2'b00, LED[m_e.bitn]};
                endcase
                if (m_e.cyc < cyc) begin
                    n_fail++;
                    $display("FAIL %s: expectation for cycle %0d missed (now %0d)", m_e.name, m_e.cyc, cyc);
                end else if (m_act !== m_e.exp) begin
                    n_fail++;
                    $display("FAIL %s @cyc %0d: got %b, expected %b", m_e.name, cyc, m_act, m_e.exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        cfg.CFG_VALID = 1'b0;
        cfg.CFG_CHAN  = '0;
        cfg.CFG_MODE  = '0;
        cfg.CFG_LEVEL = '0;

        for (int c = 1; c <= 2; c++) begin
            expect_at(c, K_LED,  0, 3'b000, "reset_led");
            expect_at(c, K_RDY,  0, 3'b000, "reset_ready");
            expect_at(c, K_TICK, 0, 3'b000, "reset_tick");
        end
        wait_cyc(2);
        RST = 1'b0;

        expect_at(3,  K_RDY,  0, 3'b001, "ready_after_release");
        expect_at(11, K_TICK, 0, 3'b000, "tick_before_first");
        expect_at(12, K_TICK, 0, 3'b001, "tick_first");
        expect_at(13, K_TICK, 0, 3'b000, "tick_after_first");
        expect_at(22, K_TICK, 0, 3'b001, "tick_second");
        expect_at(62, K_TICK, 0, 3'b001, "tick_sixth");
        expect_at(3,  K_LED,  0, 3'b111, "blink_on_start");
        expect_at(33, K_LED,  0, 3'b111, "blink_on_end");
        expect_at(34, K_LED,  0, 3'b000, "blink_off_start");
        expect_at(63, K_LED,  0, 3'b000, "blink_off_end");
        expect_at(64, K_LED,  0, 3'b111, "blink_on_again");

        // ch1 ON at level 5, then 15, then 0
        expect_at(70, K_BIT, 1, 3'b001, "ch1_before_write");
        for (int e = 71; e <= 90; e++)
            expect_at(e, K_BIT, 1, {2'b00, pwm_exp(e, 2, 5)}, "ch1_on_l5");
        for (int e = 91; e <= 110; e++)
            expect_at(e, K_BIT, 1, 3'b001, "ch1_on_l15");
        for (int e = 111; e <= 130; e++)
            expect_at(e, K_BIT, 1, 3'b000, "ch1_on_l0");
        do_write(70, 1, 1, 5);
        do_write(90, 1, 1, 15);
        do_write(110, 1, 1, 0);

        // ch2 BREATHE at level 3, then an out-of-range write
        expect_at(130, K_BIT, 2, 3'b001, "ch2_before_breathe");
        for (int e = 131; e <= 250; e++)
            expect_at(e, K_BIT, 2, {2'b00, pwm_exp(e, 2, ramp_eff(e))}, "ch2_breathe");
        for (int e = 210; e <= 250; e++)
            expect_at(e, K_BIT, 0, {2'b00, phase_after(e - 1)}, "ch0_blink_oor");
        expect_at(225, K_RDY, 0, 3'b001, "ready_oor_write");
        do_write(130, 2, 3, 3);
        do_write(225, 3, 0, 0);

        // Reset mid-breathe with a write pending
        expect_at(255, K_LED,  0, 3'b000, "rst_mid_led");
        expect_at(255, K_RDY,  0, 3'b000, "rst_mid_ready");
        expect_at(255, K_TICK, 0, 3'b000, "rst_mid_tick");
        expect_at(256, K_RDY,  0, 3'b001, "rst_mid_ready_back");
        for (int e = 256; e <= 286; e++)
            expect_at(e, K_LED, 0, 3'b111, "rst_mid_blink_on");
        expect_at(287, K_LED,  0, 3'b000, "rst_mid_blink_off");
        expect_at(264, K_TICK, 0, 3'b000, "rst_mid_tick_pre");
        expect_at(265, K_TICK, 0, 3'b001, "rst_mid_tick_first");
        wait_cyc(254);
        RST = 1'b1;
        cfg.CFG_VALID = 1'b1;
        cfg.CFG_CHAN  = 2'd0;
        cfg.CFG_MODE  = 2'd1;
        cfg.CFG_LEVEL = 4'd5;
        wait_cyc(255);
        RST = 1'b0;
        cfg.CFG_VALID = 1'b0;

        wait_cyc(295);
        while (sb.size() > 0) begin
            m_e = sb.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL %s: expectation for cycle %0d never checked", m_e.name, m_e.cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
